// File: rtl/scpu_mem_pkg.sv
// Shared definitions for the MEM-stage load/store engine: funct3 encodings,
// control-bit positions, FSM states, fault cause codes and legality helpers.
package scpu_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int M_READ_BIT  = 1;
  localparam int M_WRITE_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_TIMEOUT  = 2'b10,
    FC_BADOP    = 2'b11
  } fault_cause_e;

  function automatic logic funct3_legal(input logic [2:0] f3, input logic is_load);
    if (is_load) return f3 inside {LB, LH, LW, LBU, LHU};
    else         return f3 inside {SB, SH, SW};
  endfunction

  // Access width comes from funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
           ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobe/data replication on the issue side and
// load byte/half extraction with sign or zero extension on the completion side.
module mem_lane_align
  import scpu_mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  rbytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rbytes
    assign rbytes[gi] = rdata_i[8*gi +: 8];
  end

  assign byte_sel = rbytes[addr_lo_i];
  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = store_data_i;
    unique case (funct3_i[1:0])
      2'b00: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = store_data_i;
      end
    endcase
  end

  always_comb begin
    load_data_o = '0;
    unique case (funct3_i)
      LB:      load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      load_data_o = {{16{half_sel[15]}}, half_sel};
      LW:      load_data_o = rdata_i;
      LBU:     load_data_o = {24'h0, byte_sel};
      LHU:     load_data_o = {16'h0, half_sel};
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one request/acknowledge bus transaction per
// EX/MEM access, stalls the pipeline until it completes, then pulses result/fault.
module mem_access_unit
  import scpu_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  exmem_m,
  input  logic [31:0] exmem_alu_result,
  input  logic [31:0] exmem_rs2_data,
  input  logic [31:0] exmem_inst,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mau_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic         req_q, req_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic [31:0]  load_data_q, load_data_d;
  logic         load_valid_q, load_valid_d;
  logic         fault_q, fault_d;
  fault_cause_e cause_q, cause_d;

  logic [2:0]  funct3;
  logic        is_read, is_write, access, badop, misal;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata, lane_load;
  logic        unused_bits;

  assign funct3   = exmem_inst[14:12];
  assign is_read  = exmem_m[M_READ_BIT];
  assign is_write = exmem_m[M_WRITE_BIT];
  assign access   = is_read | is_write;
  assign badop    = (is_read & is_write) | ~funct3_legal(funct3, is_read);
  assign misal    = misaligned(funct3, exmem_alu_result[1:0]);
  assign unused_bits = ^{exmem_m[2], exmem_inst[31:15], exmem_inst[11:0]};

  // EX/MEM is frozen while stalled, so the same lane unit serves issue and completion.
  mem_lane_align u_lane (
    .funct3_i     (funct3),
    .addr_lo_i    (exmem_alu_result[1:0]),
    .store_data_i (exmem_rs2_data),
    .rdata_i      (dmem_rdata),
    .wstrb_o      (lane_wstrb),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_load)
  );

  assign stall = rst & (((state_q == IDLE) & access) | (state_q == REQ));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    fault_d      = 1'b0;
    cause_d      = FC_NONE;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          if (badop) begin
            state_d     = DONE;
            fault_d     = 1'b1;
            cause_d     = FC_BADOP;
            load_data_d = '0;
          end else if (misal) begin
            state_d     = DONE;
            fault_d     = 1'b1;
            cause_d     = FC_MISALIGN;
            load_data_d = '0;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_write;
            addr_d  = {exmem_alu_result[31:2], 2'b00};
            wdata_d = lane_wdata;
            wstrb_d = is_write ? lane_wstrb : 4'b0000;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        // An ack arriving on the final timeout cycle still counts as success.
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          if (!we_q) begin
            load_valid_d = 1'b1;
            load_data_d  = lane_load;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          wstrb_d     = 4'b0000;
          fault_d     = 1'b1;
          cause_d     = FC_TIMEOUT;
          load_data_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= FC_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_wstrb  = wstrb_q;
  assign load_data   = load_data_q;
  assign load_valid  = load_valid_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule
